// File: rtl/qdma_mc_block_engine.sv
// Multi-channel block-copy DMA engine. Channels are arbitrated round-robin and the bus is taken
// from the processor with hrq/hlda. Words are then copied through a small FIFO.
module qdma_mc_block_engine #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned AW         = 5,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    drq,
  input  logic [NCH*AW-1:0] desc_src,
  input  logic [NCH*AW-1:0] desc_dst,
  input  logic [NCH*LW-1:0] desc_len,
  input  logic [NCH*2-1:0]  desc_mode,
  output logic              hrq,
  input  logic              hlda,
  output logic [NCH-1:0]    dack,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [NCH-1:0]    done,
  output logic              busy
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StHold, StXfer, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, rr_q, rr_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [DW-1:0] fifo_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;

  logic           hrq_q, hrq_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d, busy_q, busy_d;
  logic [NCH-1:0] dack_q, dack_d, done_q, done_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;

  logic          found, do_wr, push, pop;
  logic [CW-1:0] pick, arb_idx;
  logic [AW-1:0] cur_src, cur_dst;
  logic [LW-1:0] cur_len;
  logic [1:0]    cur_mode;

  assign cur_src  = desc_src[int'(ch_q)*AW +: AW];
  assign cur_dst  = desc_dst[int'(ch_q)*AW +: AW];
  assign cur_len  = desc_len[int'(ch_q)*LW +: LW];
  assign cur_mode = desc_mode[int'(ch_q)*2 +: 2];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rr_d      = rr_q;
    mode_d    = mode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    rvalid_d  = rd_en_q;
    hrq_d     = hrq_q;
    dack_d    = dack_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = '0;
    found     = 1'b0;
    pick      = '0;
    arb_idx   = '0;
    do_wr     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    // First requester at or after rr_ptr, scanning cyclically.
    for (int i = 0; i < int'(NCH); i++) begin
      arb_idx = CW'((int'(rr_q) + i) % int'(NCH));
      if (!found && drq[arb_idx]) begin
        found = 1'b1;
        pick  = arb_idx;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          ch_d    = pick;
          hrq_d   = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (hlda) begin
          if (cur_len == '0) begin
            hrq_d       = 1'b0;
            done_d[ch_q] = 1'b1;
            state_d     = StDone;
          end else begin
            dack_d       = '0;
            dack_d[ch_q] = 1'b1;
            mode_d       = cur_mode;
            dst_d        = cur_dst;
            wr_left_d    = cur_len;
            rd_left_d    = cur_len - 1'b1;
            rd_en_d      = 1'b1;
            rd_addr_d    = cur_src;
            src_d        = (cur_mode == 2'b01) ? cur_src : cur_src + 1'b1;
            state_d      = StXfer;
          end
        end
      end
      StXfer: begin
        if (wr_left_q == '0) begin
          hrq_d        = 1'b0;
          dack_d       = '0;
          done_d[ch_q] = 1'b1;
          state_d      = StDone;
        end else begin
          // Returning read data bypasses the FIFO when it is empty and a write goes out.
          do_wr = hlda && (cnt_q != '0 || rvalid_q);
          pop   = do_wr && (cnt_q != '0);
          push  = rvalid_q && !(do_wr && cnt_q == '0);
          if (do_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dst_q;
            wr_data_d = (cnt_q != '0) ? fifo_q[rptr_q] : rd_data;
            dst_d     = (mode_q == 2'b10) ? dst_q : dst_q + 1'b1;
            wr_left_d = wr_left_q - 1'b1;
          end
          if (pop) rptr_d = rptr_q + 1'b1;
          if (push) begin
            fifo_d[wptr_q] = rd_data;
            wptr_d         = wptr_q + 1'b1;
          end
          if (push && !pop) cnt_d = cnt_q + 1'b1;
          else if (pop && !push) cnt_d = cnt_q - 1'b1;
          // Reads still outstanding must fit once they land.
          if (hlda && rd_left_q != '0 &&
              (int'(cnt_d) + int'(rd_en_q)) < int'(FIFO_DEPTH)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = src_q;
            src_d     = (mode_q == 2'b01) ? src_q : src_q + 1'b1;
            rd_left_d = rd_left_q - 1'b1;
          end
        end
      end
      StDone: begin
        rr_d    = (int'(ch_q) == int'(NCH) - 1) ? '0 : ch_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      rr_q      <= '0;
      mode_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      hrq_q     <= 1'b0;
      dack_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      hrq_q     <= hrq_d;
      dack_q    <= dack_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign hrq     = hrq_q;
  assign dack    = dack_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_qdma_mc_block_engine.sv
// Directed bench for qdma_mc_block_engine: table of block transfers plus hand sequences for
// round-robin order, hlda stall and mid-transfer reset.
module tb_qdma_mc_block_engine;
  localparam int NCH = 2;
  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int LW  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    drq;
  logic [NCH*AW-1:0] desc_src, desc_dst;
  logic [NCH*LW-1:0] desc_len;
  logic [NCH*2-1:0]  desc_mode;
  logic              hrq, hlda, rd_en, wr_en, busy;
  logic [NCH-1:0]    dack, done;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [DW-1:0]     rd_data, wr_data;

  qdma_mc_block_engine #(.NCH(NCH), .AW(AW), .DW(DW), .FIFO_DEPTH(4), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .drq(drq), .desc_src(desc_src), .desc_dst(desc_dst),
    .desc_len(desc_len), .desc_mode(desc_mode), .hrq(hrq), .hlda(hlda), .dack(dack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Read port and write port are separate arrays; a source word equals its own address.
  logic [DW-1:0] dst_mem [32];
  logic [DW-1:0] exp_mem [32];

  always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int a = 0; a < 32; a++) dst_mem[a] <= '0;
    else if (wr_en) dst_mem[wr_addr] <= wr_data;
  end

  typedef struct {
    int ch; int src; int dst; int len; int mode; int first_rd; int last_rd; int lat;
  } vec_t;
  typedef struct {
    int rd_n; int wr_n; int first_rd; int last_rd; int first_wr; int done_v; int lat;
    int dack_or; int viol;
  } stat_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_desc(input int ch, input int src, input int dst, input int len,
                          input int mode);
    desc_src[ch*AW +: AW] = AW'(src);
    desc_dst[ch*AW +: AW] = AW'(dst);
    desc_len[ch*LW +: LW] = LW'(len);
    desc_mode[ch*2 +: 2]  = 2'(mode);
  endtask

  task automatic model(input int src, input int dst, input int len, input int mode);
    for (int i = 0; i < len; i++) begin
      int s, d;
      s = (mode == 1) ? src : (src + i) % 32;
      d = (mode == 2) ? dst : (dst + i) % 32;
      exp_mem[d] = DW'(s);
    end
  endtask

  // Reports the lowest address whose contents differ, or -1.
  task automatic check_mem(input string name);
    int bad;
    bad = -1;
    for (int a = 31; a >= 0; a--) if (dst_mem[a] !== exp_mem[a]) bad = a;
    check(name, bad, -1);
  endtask

  // Grants the bus when hrq rises, then watches until done; optional 5-cycle hlda drop.
  task automatic run_xfer(input int stall_at, output stat_t st);
    int  stall_cnt;
    bit  stalled;
    st = '{default: 0};
    st.first_rd = -1; st.last_rd = -1; st.first_wr = -1; st.lat = -1;
    stall_cnt = 0;
    stalled = 1'b0;
    for (int k = 0; k < 10 && !hrq; k++) @(negedge clk);
    check("hrq_raised", int'(hrq), 1);
    hlda = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!hlda && (rd_en || wr_en)) st.viol++;
      if (rd_en) begin
        if (st.rd_n == 0) st.first_rd = int'(rd_addr);
        st.last_rd = int'(rd_addr);
        st.rd_n++;
      end
      if (wr_en) begin
        if (st.wr_n == 0) st.first_wr = k;
        st.wr_n++;
      end
      st.dack_or = st.dack_or | int'(dack);
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) hlda = 1'b1;
      end else if (!stalled && stall_at > 0 && st.wr_n == stall_at) begin
        hlda = 1'b0;
        stall_cnt = 5;
        stalled = 1'b1;
      end
      if (done != '0) begin
        st.done_v = int'(done);
        st.lat = k;
        break;
      end
    end
    hlda = 1'b0;
    if (st.lat < 0) drq = '0;
    else drq = drq & ~done;
  endtask

  initial begin
    vec_t  vt[6];
    stat_t st;
    int    nw;
    drq = '0; desc_src = '0; desc_dst = '0; desc_len = '0; desc_mode = '0;
    hlda = 1'b0; rst_n = 1'b0;
    for (int a = 0; a < 32; a++) exp_mem[a] = '0;
    // ch, src, dst, len, mode, first rd addr, last rd addr, cycles from hlda to done
    vt[0] = '{0, 10, 15, 15, 0, 10, 24, 18};
    vt[1] = '{1,  4, 20,  4, 1,  4,  4,  7};
    vt[2] = '{0,  0,  7,  4, 2,  0,  3,  7};
    vt[3] = '{1, 30,  0,  4, 0, 30,  1,  7};
    vt[4] = '{0,  5,  5,  0, 0, -1, -1,  1};
    vt[5] = '{1,  2,  9,  3, 3,  2,  4,  6};

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({hrq, dack, rd_en, wr_en, rd_addr, wr_addr, wr_data, done, busy}),
          0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      set_desc(vt[v].ch, vt[v].src, vt[v].dst, vt[v].len, vt[v].mode);
      drq[vt[v].ch] = 1'b1;
      run_xfer(0, st);
      model(vt[v].src, vt[v].dst, vt[v].len, vt[v].mode);
      check($sformatf("v%0d_wr_count", v), st.wr_n, vt[v].len);
      check($sformatf("v%0d_rd_count", v), st.rd_n, vt[v].len);
      check($sformatf("v%0d_done_ch", v), st.done_v, 1 << vt[v].ch);
      check($sformatf("v%0d_latency", v), st.lat, vt[v].lat);
      if (vt[v].len > 0) begin
        check($sformatf("v%0d_first_rd", v), st.first_rd, vt[v].first_rd);
        check($sformatf("v%0d_last_rd", v), st.last_rd, vt[v].last_rd);
        check($sformatf("v%0d_first_wr", v), st.first_wr, 3);
        check($sformatf("v%0d_dack", v), st.dack_or, 1 << vt[v].ch);
      end else begin
        check($sformatf("v%0d_dack", v), st.dack_or, 0);
      end
      check_mem($sformatf("v%0d_mem_bad_addr", v));
      @(negedge clk);
    end

    // Round-robin: ch0 wins first, ch0 re-requests while ch1 waits, ch1 must go next.
    set_desc(0, 0, 24, 3, 0);
    set_desc(1, 3, 27, 3, 0);
    drq = 2'b11;
    run_xfer(0, st);
    check("rr_first", st.done_v, 1);
    drq[0] = 1'b1;
    run_xfer(0, st);
    check("rr_second", st.done_v, 2);
    run_xfer(0, st);
    check("rr_third", st.done_v, 1);
    model(0, 24, 3, 0);
    model(3, 27, 3, 0);
    check_mem("rr_mem_bad_addr");
    @(negedge clk);

    // hlda dropped for 5 cycles after the 3rd write.
    set_desc(0, 8, 16, 8, 0);
    drq[0] = 1'b1;
    run_xfer(3, st);
    model(8, 16, 8, 0);
    check("stall_strobes", st.viol, 0);
    check("stall_wr_count", st.wr_n, 8);
    check("stall_rd_count", st.rd_n, 8);
    check("stall_done_ch", st.done_v, 1);
    check("stall_latency", st.lat, 16);
    check_mem("stall_mem_bad_addr");
    @(negedge clk);

    // Reset asserted after the 5th write of a 15-word block.
    set_desc(0, 0, 0, 15, 0);
    drq[0] = 1'b1;
    for (int k = 0; k < 10 && !hrq; k++) @(negedge clk);
    hlda = 1'b1;
    nw = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wr_en) nw++;
      if (nw == 5) break;
    end
    check("rst_mid_reached", nw, 5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          int'({hrq, dack, rd_en, wr_en, rd_addr, wr_addr, wr_data, done, busy}), 0);
    drq = '0;
    hlda = 1'b0;
    for (int a = 0; a < 32; a++) exp_mem[a] = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", int'({busy, hrq}), 0);
    set_desc(1, 12, 3, 2, 0);
    drq[1] = 1'b1;
    run_xfer(0, st);
    model(12, 3, 2, 0);
    check("post_rst_wr_count", st.wr_n, 2);
    check("post_rst_done_ch", st.done_v, 2);
    check("post_rst_latency", st.lat, 5);
    check_mem("post_rst_mem_bad_addr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/qdma_mc_block_engine.md
# qdma_mc_block_engine

Parametrised multi-channel successor to the single-channel QDMA block-transfer engine. It arbitrates up to NCH channel requests round-robin and acquires the bus from the processor via the hrq/hlda hold handshake. It then moves a block of words from a source address to a destination address through an internal FIFO, using external synchronous read/write memory ports. It adds address modes, zero-length handling, bus-release stall and address wrap, none of which the first-generation engine supports.

## Interface
- NCH, 2: number of DMA channels (1..8).
- AW, 5: address width; address space wraps modulo 2^AW.
- DW, 8: data word width.
- FIFO_DEPTH, 4: staging FIFO depth (power of 2, >=2).
- LW, AW+1: length field width (max block 2^AW words).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- drq  in  NCH  per-channel request level; held until that channel's done.
- desc_src  in  NCH*AW  per-channel source address (channel c at bits [c*AW +: AW]).
- desc_dst  in  NCH*AW  per-channel destination address.
- desc_len  in  NCH*LW  per-channel word count.
- desc_mode  in  NCH*2  00 incr src/incr dst, 01 fixed src (peripheral port), 10 fixed dst, 11 reserved (treated as 00).
- hrq  out  1  hold request to processor.
- hlda  in  1  hold acknowledge from processor; may drop at any time.
- dack  out  NCH  one-hot grant, level, for the active channel.
- rd_en  out  1  memory read strobe.
- rd_addr  out  AW  read address.
- rd_data  in  DW  read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  memory write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  DW  write data.
- done  out  NCH  one-cycle completion pulse for the channel.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, HOLD, XFER, DONE.
- IDLE: if any drq bit set, latch the winning channel and go to HOLD. Winner is the first requesting channel at or after rr_ptr (cyclic).
- HOLD: hrq=1, wait for hlda=1. Then latch the winner's descriptor into src/dst/remaining counters, assert dack[ch], and go to XFER.
- XFER: issue a read when rd_left>0, hlda=1, and fifo_count + inflight < FIFO_DEPTH. The read result is pushed into the FIFO the next cycle. Issue a write when the FIFO is not empty and hlda=1. Push and pop in the same cycle leave the count unchanged.
- Address step: src +1 per read unless mode 01; dst +1 per write unless mode 10; sums truncated to AW bits (31+1 -> 0 at AW=5).
- Zero length: HOLD -> DONE directly, with no rd_en/wr_en.
- Go to DONE when wr_left reaches 0.
- DONE (1 cycle): done[ch]=1, hrq=0, dack=0, rr_ptr = ch+1 mod NCH, then go to IDLE.
- hlda drop in XFER: no new rd_en/wr_en; an in-flight read is still captured into the FIFO; hrq stays 1; resume on the cycle hlda returns.
- Channel drq drop after grant: ignored; the block completes.
- Reset (any time, including mid-transfer): state IDLE; counters, FIFO and rr_ptr cleared; all outputs 0.

## Timing
- Reset values: hrq=0, dack=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, done=0, busy=0.
- IDLE -> HOLD: 1 cycle after drq is sampled.
- hrq to first XFER cycle: 1 cycle after hlda is sampled high.
- XFER with len N>0, hlda steady: rd_en on XFER cycles 0..N-1; wr_en on cycles 2..N+1. Throughput 1 word/cycle.
- Done pulse: 1 cycle after the last wr_en. Total from HOLD exit to done = N+2 cycles.
- Outputs are registered; rd_addr/wr_addr/wr_data are valid in the same cycle as their strobes.

## Test plan
- Single block: ch0 src=10, dst=15, len=15, mode 00, mem[10+i]=10+i. Required: mem[15+i]=10+i for i=0..14; 15 wr_en pulses; done[0] one cycle after the last write.
- Round-robin: drq=2'b11 simultaneously, ch0 len 3, ch1 len 3. Required: ch0 served first, then ch1; after another 2'b11, ch1 is served before ch0.
- hlda stall: ch0 len 8; drop hlda for 5 cycles after the 3rd write. Required: no strobes during the drop; no data lost or duplicated; done after resume.
- Modes: mode 01 src=4 len 4 reads addr 4 four times; mode 10 dst=7 leaves only the last word at mem[7].
- Wrap and zero length: src=30, dst=0, len 4 reads addr 30, 31, 0, 1. A len 0 request gives done within 3 cycles of hlda with no rd_en/wr_en.
- Reset mid-transfer: assert rst_n=0 after the 5th write of len 15. Required: all outputs 0 immediately; after release the engine is IDLE and accepts a new request normally.
